// File: rtl/bf_stdout_uart.sv
// bf_stdout_uart
// Output stage of the brainfuck CPU: buffers bytes written by the `.`
// instruction in a small FIFO and serializes them as 8N1 UART frames.
//
// Ports:
//   clk          - single clock for the whole block
//   rst          - synchronous, active-high reset
//   stdout       - byte written by the CPU
//   stdout_en    - one-cycle write strobe, qualified by stdout_ready
//   stdout_ready - FIFO not full; the CPU stalls its `.` while low
//   uart_tx_pin  - serial output, idles high, driven from a flop
//   tx_busy      - a frame is on the line or bytes are still buffered
//   overflow     - sticky, set when a write is dropped on a full FIFO
//   fifo_count   - current FIFO occupancy
//
// Serializer states:
//   state   | meaning
//   S_IDLE  | line idle (pin 1), waiting for a buffered byte
//   S_START | start bit (pin 0) for CLKS_PER_BIT cycles
//   S_DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
//   S_STOP  | stop bit (pin 1); pops straight into S_START if more data

module bf_stdout_uart #(
   parameter int CLKS_PER_BIT    = 1,
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 stdout,
   input  logic                       stdout_en,
   output logic                       stdout_ready,
   output logic                       uart_tx_pin,
   output logic                       tx_busy,
   output logic                       overflow,
   output logic [FIFO_DEPTH_LOG2:0]   fifo_count
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int CNTW  = FIFO_DEPTH_LOG2 + 1;
   localparam int CW    = $clog2(CLKS_PER_BIT) + 1;

   localparam logic [CW-1:0]              BIT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]              BAUD_ONE = CW'(1);
   localparam logic [CNTW-1:0]            FULL_CNT = CNTW'(DEPTH);
   localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t state, state_next;

   logic [7:0]                 mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [CNTW-1:0]            count_next;
   logic [CW-1:0]              baud_cnt, baud_next;
   logic [2:0]                 bit_idx, bit_idx_next;
   logic [7:0]                 shreg, shreg_next;
   logic                       pin_next;
   logic                       wr_acc, pop, bit_end, fifo_nonempty;

   assign stdout_ready  = (fifo_count != FULL_CNT);
   assign wr_acc        = stdout_en && stdout_ready;
   assign fifo_nonempty = (fifo_count != '0);
   assign bit_end       = (baud_cnt == BIT_LAST);
   assign count_next    = fifo_count + CNTW'(wr_acc) - CNTW'(pop);

   // Storage is not reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= stdout;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
         fifo_count <= count_next;
         // A write on a full FIFO is dropped even if a pop frees a slot
         // on the same edge, since readiness comes from the registered count.
         if (stdout_en && !stdout_ready) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (fifo_nonempty) state_next = S_START;
         S_START: if (bit_end) state_next = S_DATA;
         S_DATA:  if (bit_end && bit_idx == 3'd7) state_next = S_STOP;
         S_STOP:  if (bit_end) state_next = fifo_nonempty ? S_START : S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // pin_next is the value the line takes after the coming edge, so the
   // pin flop always presents the bit of the current state.
   always_comb begin
      pop          = 1'b0;
      pin_next     = uart_tx_pin;
      shreg_next   = shreg;
      bit_idx_next = bit_idx;
      baud_next    = bit_end ? '0 : baud_cnt + BAUD_ONE;
      case (state)
         S_IDLE: begin
            baud_next = '0;
            pin_next  = 1'b1;
            if (fifo_nonempty) begin
               pop        = 1'b1;
               shreg_next = mem[rd_ptr];
               pin_next   = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               pin_next     = shreg[0];
               bit_idx_next = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_idx == 3'd7) begin
                  pin_next = 1'b1;
               end else begin
                  pin_next     = shreg[1];
                  shreg_next   = {1'b0, shreg[7:1]};
                  bit_idx_next = bit_idx + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (bit_end && fifo_nonempty) begin
               pop        = 1'b1;
               shreg_next = mem[rd_ptr];
               pin_next   = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         baud_cnt    <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         uart_tx_pin <= 1'b1;
         tx_busy     <= 1'b0;
      end else begin
         baud_cnt    <= baud_next;
         bit_idx     <= bit_idx_next;
         shreg       <= shreg_next;
         uart_tx_pin <= pin_next;
         tx_busy     <= (state_next != S_IDLE) || (count_next != '0);
      end
   end

endmodule

// File: tb/tb_bf_stdout_uart.sv
// Testbench for bf_stdout_uart (CLKS_PER_BIT=4, 4-entry FIFO).
// A queue-based reference model predicts every output each cycle; a
// mid-bit UART receiver decodes the line and is compared against the
// bytes the model says were fully transmitted.

module tb_bf_stdout_uart;

   localparam int C     = 4;
   localparam int L2    = 2;
   localparam int DEPTH = 1 << L2;
   localparam int FRAME = 10 * C;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    stdout;
   logic          stdout_en;
   logic          stdout_ready;
   logic          uart_tx_pin;
   logic          tx_busy;
   logic          overflow;
   logic [L2:0]   fifo_count;

   always #5 clk = ~clk;

   bf_stdout_uart #(.CLKS_PER_BIT(C), .FIFO_DEPTH_LOG2(L2)) dut (
      .clk          (clk),
      .rst          (rst),
      .stdout       (stdout),
      .stdout_en    (stdout_en),
      .stdout_ready (stdout_ready),
      .uart_tx_pin  (uart_tx_pin),
      .tx_busy      (tx_busy),
      .overflow     (overflow),
      .fifo_count   (fifo_count)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   byte unsigned mq[$];
   byte unsigned m_tx[$];
   bit           m_in_frame = 0;
   int           m_pos = 0;
   byte unsigned m_cur = 0;
   bit           m_ovf = 0;
   int           m_sz;
   bit           m_pop;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_in_frame = 0;
         m_pos      = 0;
         m_ovf      = 0;
      end else begin
         m_sz  = mq.size();
         m_pop = (m_sz > 0) && (!m_in_frame || m_pos == FRAME - 1);
         if (m_in_frame && m_pos == FRAME - 1) begin
            m_tx.push_back(m_cur);
            m_in_frame = 0;
         end else if (m_in_frame) begin
            m_pos++;
         end
         if (m_pop) begin
            m_cur      = mq.pop_front();
            m_in_frame = 1;
            m_pos      = 0;
         end
         if (stdout_en) begin
            if (m_sz < DEPTH) mq.push_back(stdout);
            else              m_ovf = 1;
         end
      end
   end

   function automatic int exp_pin();
      int k;
      if (!m_in_frame) return 1;
      k = m_pos / C;
      if (k == 0) return 0;
      if (k <= 8) return int'(m_cur[k-1]);
      return 1;
   endfunction

   bit chk_on = 0;
   int pk = 0;

   always @(negedge clk) begin
      if (chk_on) begin
         chk("pin",        int'(uart_tx_pin),  exp_pin());
         chk("fifo_count", int'(fifo_count),   mq.size());
         chk("ready",      int'(stdout_ready), int'(mq.size() < DEPTH));
         chk("tx_busy",    int'(tx_busy),      int'(m_in_frame || mq.size() > 0));
         chk("overflow",   int'(overflow),     int'(m_ovf));
         if (int'(fifo_count) > pk) pk = int'(fifo_count);
      end
   end

   // ---------------- UART receiver on the DUT pin ----------------
   bit           rx_act = 0;
   int           rx_t = 0;
   int           rx_rel;
   byte unsigned rx_b = 0;
   byte unsigned rx_q[$];

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         rx_act = 0;
      end else begin
         if (!rx_act) begin
            if (uart_tx_pin === 1'b0) begin
               rx_act = 1;
               rx_t   = 0;
            end
         end else begin
            rx_t++;
         end
         if (rx_act) begin
            rx_rel = rx_t - C / 2;
            if (rx_rel >= 0 && rx_rel % C == 0) begin
               if (rx_rel / C == 0) begin
                  chk("rx_start", int'(uart_tx_pin), 0);
               end else if (rx_rel / C <= 8) begin
                  rx_b[rx_rel / C - 1] = uart_tx_pin;
               end else begin
                  chk("rx_stop", int'(uart_tx_pin), 1);
                  rx_q.push_back(rx_b);
                  rx_act = 0;
               end
            end
         end
      end
   end

   // ---------------- driver helpers ----------------
   byte unsigned hand_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit r, input bit en, input byte unsigned d);
      rst       = r;
      stdout_en = en;
      stdout    = d;
      tick();
   endtask

   task automatic wait_idle(input string nm, output int n);
      n = 0;
      while (tx_busy !== 1'b0 && n < 2000) begin
         drive(0, 0, 8'h00);
         n++;
      end
      if (tx_busy !== 1'b0) chk({nm, "_idle_timeout"}, int'(tx_busy), 0);
   endtask

   task automatic check_rx(input string nm);
      chk({nm, "_rx_count"}, rx_q.size(), m_tx.size());
      for (int i = 0; i < rx_q.size() && i < m_tx.size(); i++)
         chk($sformatf("%s_rx_byte[%0d]", nm, i), rx_q[i], m_tx[i]);
      if (hand_q.size() > 0) begin
         chk({nm, "_rx_count_hand"}, rx_q.size(), hand_q.size());
         for (int i = 0; i < rx_q.size() && i < hand_q.size(); i++)
            chk($sformatf("%s_rx_hand[%0d]", nm, i), rx_q[i], hand_q[i]);
      end
      rx_q.delete();
      m_tx.delete();
      hand_q.delete();
   endtask

   typedef struct {
      bit           r;
      bit           en;
      byte unsigned d;
      bit           pin;
      int           cnt;
      bit           rdy;
      bit           busy;
      bit           ovf;
   } vec_t;

   vec_t tv[5];
   int   n;
   int   idx;
   int   guard;

   initial begin
      rst = 1'b1; stdout_en = 1'b0; stdout = 8'h00;

      // Test 1: reset then a single 0x48, cycle by cycle through the pop.
      tv[0] = '{1, 0, 8'h00, 1, 0, 1, 0, 0};
      tv[1] = '{1, 0, 8'h00, 1, 0, 1, 0, 0};
      tv[2] = '{0, 0, 8'h00, 1, 0, 1, 0, 0};
      tv[3] = '{0, 1, 8'h48, 1, 1, 1, 1, 0};
      tv[4] = '{0, 0, 8'h00, 0, 0, 1, 1, 0};
      for (int i = 0; i < 5; i++) begin
         drive(tv[i].r, tv[i].en, tv[i].d);
         chk_on = 1;
         chk($sformatf("t1[%0d]_pin", i),   int'(uart_tx_pin),  int'(tv[i].pin));
         chk($sformatf("t1[%0d]_count", i), int'(fifo_count),   tv[i].cnt);
         chk($sformatf("t1[%0d]_ready", i), int'(stdout_ready), int'(tv[i].rdy));
         chk($sformatf("t1[%0d]_busy", i),  int'(tx_busy),      int'(tv[i].busy));
         chk($sformatf("t1[%0d]_ovf", i),   int'(overflow),     int'(tv[i].ovf));
      end
      wait_idle("t1", n);
      chk("t1_frame_len", n, FRAME);
      hand_q.push_back(8'h48);
      check_rx("t1");

      // Test 2: "Hi\n" on consecutive edges, frames back to back.
      pk = 0;
      drive(0, 1, 8'h48);
      drive(0, 1, 8'h69);
      drive(0, 1, 8'h0A);
      wait_idle("t2", n);
      chk("t2_span", n + 1, 3 * FRAME);
      chk("t2_peak", pk, 2);
      hand_q.push_back(8'h48); hand_q.push_back(8'h69); hand_q.push_back(8'h0A);
      check_rx("t2");

      // Test 3: six writes into a 4-entry FIFO; one pop frees a slot early.
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, byte'(8'h41 + i));
         if (i == 4) begin
            chk("t3_full_ready", int'(stdout_ready), 0);
            chk("t3_full_count", int'(fifo_count), 4);
         end
         if (i == 5) begin
            chk("t3_ovf_set", int'(overflow), 1);
            chk("t3_drop_count", int'(fifo_count), 4);
         end
      end
      wait_idle("t3", n);
      chk("t3_ovf_sticky", int'(overflow), 1);
      for (int i = 0; i < 5; i++) hand_q.push_back(byte'(8'h41 + i));
      check_rx("t3");
      drive(1, 0, 8'h00);
      chk("t3_ovf_cleared", int'(overflow), 0);
      drive(0, 0, 8'h00);

      // Test 4: write and pop on the same edge, from IDLE and from STOP.
      drive(0, 1, 8'hA5);
      chk("t4_count_a", int'(fifo_count), 1);
      drive(0, 1, 8'h3C);
      chk("t4_count_b", int'(fifo_count), 1);
      for (int i = 0; i < FRAME - 1; i++) drive(0, 0, 8'h00);
      chk("t4_stop_pin", int'(uart_tx_pin), 1);
      drive(0, 1, 8'hF0);
      chk("t4_count_c", int'(fifo_count), 1);
      chk("t4_no_gap_pin", int'(uart_tx_pin), 0);
      wait_idle("t4", n);
      hand_q.push_back(8'hA5); hand_q.push_back(8'h3C); hand_q.push_back(8'hF0);
      check_rx("t4");

      // Test 5: reset during data bit 3 with two bytes buffered.
      drive(0, 1, 8'h11);
      drive(0, 1, 8'h22);
      drive(0, 1, 8'h33);
      for (int i = 0; i < 16; i++) drive(0, 0, 8'h00);
      chk("t5_buffered", int'(fifo_count), 2);
      drive(1, 0, 8'h00);
      chk("t5_pin_after_rst", int'(uart_tx_pin), 1);
      chk("t5_count_after_rst", int'(fifo_count), 0);
      for (int i = 0; i < 100; i++) drive(0, 0, 8'h00);
      chk("t5_quiet", int'(tx_busy), 0);
      check_rx("t5");

      // Test 6: 20 bytes through the 4-entry FIFO, writing only when ready.
      idx = 0; guard = 0;
      while (idx < 20 && guard < 5000) begin
         if (stdout_ready === 1'b1) begin
            drive(0, 1, byte'(idx));
            idx++;
         end else begin
            drive(0, 0, 8'h00);
         end
         guard++;
      end
      chk("t6_sent", idx, 20);
      wait_idle("t6", n);
      chk("t6_no_ovf", int'(overflow), 0);
      for (int i = 0; i < 20; i++) hand_q.push_back(byte'(i));
      check_rx("t6");

      // Randomized traffic against the model.
      drive(1, 0, 8'h00);
      for (int i = 0; i < 600; i++)
         drive(0, ($urandom_range(0, 99) < 35), byte'($urandom));
      wait_idle("rnd", n);
      check_rx("rnd");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
